operand_capture: RTL and testbench

Front-end operand stage for the 4-bit ripple adder on the Nexys2 board. It synchronises and debounces three push buttons and latches the 4 slide switches into operand registers A and B. It tracks which operands have been loaded and presents stable `a`, `b` and `ci` to the adder chain, whose half/full-adder cells consume them directly. A `ready` level and an `update` pulse let downstream display or result logic know when a complete operand pair is present.

---
 rtl/operand_capture.sv | 249 ++++++++++++++++++++++++
 tb/tb_operand_capture.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_capture.sv
// -----------------------------------------------------------------------------
// operand_capture
//
// Front-end operand stage for the 4-bit ripple adder on the Nexys2 board.
// Synchronises the slide switches and push buttons, debounces the buttons,
// and latches the switch value into operand registers A and B. It tracks
// which operands have been loaded, so downstream logic can tell when a
// complete pair is present.
//
// Ports:
//   clk      in   1      system clock (50 MHz), only clock in the block
//   rst      in   1      asynchronous active-high reset
//   sw       in   WIDTH  raw slide switches, operand value source
//   sw_ci    in   1      raw carry-in switch
//   btn_a    in   1      raw button, press loads A
//   btn_b    in   1      raw button, press loads B
//   btn_clr  in   1      raw button, press clears both operands
//   a        out  WIDTH  registered operand A
//   b        out  WIDTH  registered operand B
//   ci       out  1      registered carry-in
//   ready    out  1      both operands loaded since last clear/reset
//   update   out  1      one-cycle pulse after a load that leaves a full pair
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// operand_capture_debounce
//
// Debouncer for one already-synchronised button. The filtered level only
// follows the input after DEBOUNCE_CYCLES consecutive cycles of disagreement.
//
// Ports:
//   clk      in   1  system clock
//   rst      in   1  asynchronous active-high reset
//   level_i  in   1  synchronised button level
//   press_o  out  1  combinational, high on the edge where a 0->1 change commits
// -----------------------------------------------------------------------------
module operand_capture_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic level_i,
   output logic press_o
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   // The commit happens on the edge where the count would reach the threshold,
   // so the largest value ever held in the register is DEBOUNCE_CYCLES-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             stable_q;
   logic             stable_d;

   // Next-state for the disagreement counter and the filtered level.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      press_o  = 1'b0;
      if (level_i == stable_q) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q >= CNT_LAST) begin
         // Saturating compare: the counter can never run past the threshold.
         stable_d = level_i;
         cnt_d    = {CNT_W{1'b0}};
         press_o  = level_i;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter and filtered-level registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= {CNT_W{1'b0}};
         stable_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

endmodule

module operand_capture #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned WIDTH           = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   input  logic             sw_ci,
   input  logic             btn_a,
   input  logic             btn_b,
   input  logic             btn_clr,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             ci,
   output logic             ready,
   output logic             update
);

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_A_ONLY = 2'd1,
      ST_B_ONLY = 2'd2,
      ST_BOTH   = 2'd3
   } state_t;

   // Two-flop synchronisers for every asynchronous input.
   logic [WIDTH-1:0] sw_meta_q;
   logic [WIDTH-1:0] sw_sync_q;
   logic             ci_meta_q;
   logic             ci_sync_q;
   logic [2:0]       btn_meta_q;
   logic [2:0]       btn_sync_q;

   logic             load_a_evt_s;
   logic             load_b_evt_s;
   logic             clr_evt_s;
   logic             have_a_s;
   logic             have_b_s;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] b_d;
   logic             ci_q;
   logic             ci_d;
   logic             update_q;
   logic             update_d;

   // Input synchroniser chains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_meta_q  <= {WIDTH{1'b0}};
         sw_sync_q  <= {WIDTH{1'b0}};
         ci_meta_q  <= 1'b0;
         ci_sync_q  <= 1'b0;
         btn_meta_q <= 3'b000;
         btn_sync_q <= 3'b000;
      end else begin
         sw_meta_q  <= sw;
         sw_sync_q  <= sw_meta_q;
         ci_meta_q  <= sw_ci;
         ci_sync_q  <= ci_meta_q;
         btn_meta_q <= {btn_clr, btn_b, btn_a};
         btn_sync_q <= btn_meta_q;
      end
   end

   operand_capture_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_a (
      .clk     (clk),
      .rst     (rst),
      .level_i (btn_sync_q[0]),
      .press_o (load_a_evt_s)
   );

   operand_capture_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_b (
      .clk     (clk),
      .rst     (rst),
      .level_i (btn_sync_q[1]),
      .press_o (load_b_evt_s)
   );

   operand_capture_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_clr (
      .clk     (clk),
      .rst     (rst),
      .level_i (btn_sync_q[2]),
      .press_o (clr_evt_s)
   );

   // Which operands will be present after this edge, ignoring clear.
   always_comb begin
      have_a_s = (state_q == ST_A_ONLY) || (state_q == ST_BOTH) || load_a_evt_s;
      have_b_s = (state_q == ST_B_ONLY) || (state_q == ST_BOTH) || load_b_evt_s;
   end

   // Operand FSM: next state, operand registers and update pulse.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      ci_d     = ci_q;
      update_d = 1'b0;
      if (clr_evt_s) begin
         // Clear wins over any load committing on the same edge.
         state_d = ST_EMPTY;
         a_d     = {WIDTH{1'b0}};
         b_d     = {WIDTH{1'b0}};
         ci_d    = 1'b0;
      end else if (load_a_evt_s || load_b_evt_s) begin
         if (load_a_evt_s) begin
            a_d = sw_sync_q;
         end else begin
            a_d = a_q;
         end
         if (load_b_evt_s) begin
            b_d = sw_sync_q;
         end else begin
            b_d = b_q;
         end
         ci_d = ci_sync_q;
         case ({have_a_s, have_b_s})
            2'b11:   state_d = ST_BOTH;
            2'b10:   state_d = ST_A_ONLY;
            2'b01:   state_d = ST_B_ONLY;
            default: state_d = ST_EMPTY;
         endcase
         // Reloads while already full also announce a fresh pair.
         update_d = have_a_s && have_b_s;
      end else begin
         state_d = state_q;
      end
   end

   // State, operand and pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         a_q      <= {WIDTH{1'b0}};
         b_q      <= {WIDTH{1'b0}};
         ci_q     <= 1'b0;
         update_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ci_q     <= ci_d;
         update_q <= update_d;
      end
   end

   assign a      = a_q;
   assign b      = b_q;
   assign ci     = ci_q;
   assign ready  = (state_q == ST_BOTH);
   assign update = update_q;

endmodule

// File: tb/tb_operand_capture.sv
// Bench for operand_capture with DEBOUNCE_CYCLES=4, WIDTH=4.
// A reference model predicts the outputs from input history: a button press
// is accepted once the last DB synchronised samples (raw samples delayed two
// edges) all read high while the filtered level is low.
module tb_operand_capture;

   localparam int DB = 4;
   localparam int W  = 4;

   logic         clk;
   logic         rst;
   logic [W-1:0] sw;
   logic         sw_ci;
   logic         btn_a;
   logic         btn_b;
   logic         btn_clr;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ci;
   logic         ready;
   logic         update;

   int tests;
   int fails;
   int upd_cnt;

   operand_capture #(
      .DEBOUNCE_CYCLES (DB),
      .WIDTH           (W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sw      (sw),
      .sw_ci   (sw_ci),
      .btn_a   (btn_a),
      .btn_b   (btn_b),
      .btn_clr (btn_clr),
      .a       (a),
      .b       (b),
      .ci      (ci),
      .ready   (ready),
      .update  (update)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [15:0]  hist [3];     // bit0 = most recent raw sample
   logic [2:0]   lvl_m;        // filtered button levels
   logic [2:0]   press_m;
   logic [2:0]   rel_m;
   logic [W-1:0] sw_h1, sw_h2;
   logic         ci_h1, ci_h2;
   logic [W-1:0] m_a, m_b;
   logic         m_ci, m_la, m_lb, m_upd;
   logic [2:0]   raw_btn;

   assign raw_btn = {btn_clr, btn_b, btn_a};

   always_comb begin
      press_m = 3'b000;
      rel_m   = 3'b000;
      for (int i = 0; i < 3; i++) begin
         press_m[i] = !lvl_m[i] && (&hist[i][DB:1]);
         rel_m[i]   = lvl_m[i] && !(|hist[i][DB:1]);
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) hist[i] <= 16'h0000;
         lvl_m <= 3'b000;
         sw_h1 <= '0; sw_h2 <= '0; ci_h1 <= 1'b0; ci_h2 <= 1'b0;
         m_a <= '0; m_b <= '0; m_ci <= 1'b0; m_la <= 1'b0; m_lb <= 1'b0; m_upd <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            hist[i]  <= {hist[i][14:0], raw_btn[i]};
            lvl_m[i] <= press_m[i] ? 1'b1 : (rel_m[i] ? 1'b0 : lvl_m[i]);
         end
         sw_h1 <= sw; sw_h2 <= sw_h1;
         ci_h1 <= sw_ci; ci_h2 <= ci_h1;
         m_upd <= 1'b0;
         if (press_m[2]) begin
            m_a <= '0; m_b <= '0; m_ci <= 1'b0; m_la <= 1'b0; m_lb <= 1'b0;
         end else if (press_m[0] || press_m[1]) begin
            if (press_m[0]) begin m_a <= sw_h2; m_la <= 1'b1; end
            if (press_m[1]) begin m_b <= sw_h2; m_lb <= 1'b1; end
            m_ci  <= ci_h2;
            m_upd <= (press_m[0] || m_la) && (press_m[1] || m_lb);
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one cycle and compare every output against the model.
   task automatic step();
      @(negedge clk);
      check("model_a",      {28'd0, a},      {28'd0, m_a});
      check("model_b",      {28'd0, b},      {28'd0, m_b});
      check("model_ci",     {31'd0, ci},     {31'd0, m_ci});
      check("model_ready",  {31'd0, ready},  {31'd0, m_la && m_lb});
      check("model_update", {31'd0, update}, {31'd0, m_upd});
      if (update === 1'b1) upd_cnt++;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      tests = 0; fails = 0; upd_cnt = 0;
      rst = 1'b1; sw = 4'b0000; sw_ci = 1'b0;
      btn_a = 1'b0; btn_b = 1'b0; btn_clr = 1'b0;
      steps(3);
      check("rst_a", {28'd0, a}, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd0);
      rst = 1'b0;
      steps(3);

      // Load pair: A first, check latency of DB+2 edges.
      sw = 4'b1011; sw_ci = 1'b1; btn_a = 1'b1;
      steps(5);
      check("lat_a_before", {28'd0, a}, 32'd0);
      step();
      check("lat_a_loaded", {28'd0, a}, 32'd11);
      check("lat_ready_a_only", {31'd0, ready}, 32'd0);
      steps(4);
      btn_a = 1'b0;
      steps(8);
      upd_cnt = 0;
      sw = 4'b0110; btn_b = 1'b1;
      steps(5);
      check("pair_ready_before", {31'd0, ready}, 32'd0);
      step();
      check("pair_b", {28'd0, b}, 32'd6);
      check("pair_ci", {31'd0, ci}, 32'd1);
      check("pair_ready", {31'd0, ready}, 32'd1);
      check("pair_update_hi", {31'd0, update}, 32'd1);
      step();
      check("pair_update_lo", {31'd0, update}, 32'd0);
      steps(3);
      btn_b = 1'b0;
      steps(8);
      check("pair_update_count", upd_cnt, 32'd1);

      // Bounce rejection: 1, 2, 3 cycle highs with 1-cycle lows.
      upd_cnt = 0;
      for (int p = 1; p <= 3; p++) begin
         btn_a = 1'b1; steps(p);
         btn_a = 1'b0; steps(1);
      end
      steps(8);
      check("bounce_a", {28'd0, a}, 32'd11);
      check("bounce_ready", {31'd0, ready}, 32'd1);
      check("bounce_update_count", upd_cnt, 32'd0);

      // Held button in BOTH: exactly one reload.
      upd_cnt = 0;
      sw = 4'b1111; btn_b = 1'b1;
      steps(50);
      btn_b = 1'b0;
      steps(8);
      check("held_b", {28'd0, b}, 32'd15);
      check("held_a", {28'd0, a}, 32'd11);
      check("held_update_count", upd_cnt, 32'd1);

      // Clear priority over a simultaneous load.
      upd_cnt = 0;
      btn_clr = 1'b1; btn_a = 1'b1;
      steps(8);
      check("clr_a", {28'd0, a}, 32'd0);
      check("clr_b", {28'd0, b}, 32'd0);
      check("clr_ci", {31'd0, ci}, 32'd0);
      check("clr_ready", {31'd0, ready}, 32'd0);
      btn_clr = 1'b0; btn_a = 1'b0;
      steps(8);
      sw = 4'b1001; sw_ci = 1'b0; btn_a = 1'b1;
      steps(8);
      btn_a = 1'b0;
      steps(8);
      check("clr_then_a", {28'd0, a}, 32'd9);
      check("clr_then_ready", {31'd0, ready}, 32'd0);
      check("clr_update_count", upd_cnt, 32'd0);

      // Simultaneous loads from EMPTY.
      btn_clr = 1'b1; steps(8); btn_clr = 1'b0; steps(8);
      upd_cnt = 0;
      sw = 4'b0101; btn_a = 1'b1; btn_b = 1'b1;
      steps(8);
      btn_a = 1'b0; btn_b = 1'b0;
      steps(8);
      check("sim_a", {28'd0, a}, 32'd5);
      check("sim_b", {28'd0, b}, 32'd5);
      check("sim_ready", {31'd0, ready}, 32'd1);
      check("sim_update_count", upd_cnt, 32'd1);

      // Mid-cycle reset with buttons idle clears everything immediately.
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_a", {28'd0, a}, 32'd0);
      check("mid_rst_b", {28'd0, b}, 32'd0);
      check("mid_rst_ci", {31'd0, ci}, 32'd0);
      check("mid_rst_ready", {31'd0, ready}, 32'd0);
      check("mid_rst_update", {31'd0, update}, 32'd0);
      steps(2);
      rst = 1'b0;
      steps(3);

      // Reset in the middle of a debounce; the held button counts afresh.
      sw = 4'b0111; sw_ci = 1'b1; btn_a = 1'b1;
      steps(4);
      rst = 1'b1;
      steps(2);
      rst = 1'b0;
      steps(5);
      check("rst_db_pending", {28'd0, a}, 32'd0);
      steps(5);
      check("rst_db_a", {28'd0, a}, 32'd7);
      check("rst_db_ready", {31'd0, ready}, 32'd0);
      btn_a = 1'b0;
      steps(8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
